// File: rtl/lu_truth_table_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lu_truth_table_sequencer
// Description : Stimulus and capture stage for the 1-bit OR/NOR logic unit.
//               On start, drives every input combination {lu_sel,lu_a,lu_b}
//               into the LU in ascending order. Each combination is held for
//               HOLD cycles, and then the LU output is sampled. The samples
//               are packed into a truth-table vector, and done pulses when
//               the vector is complete.
//               Optional feature macro: LU_CHECK_EN. When it is defined, a
//               mismatch output flags result != EXPECTED.
// Revision    : 1.0 - initial release
// ============================================================================
module lu_truth_table_sequencer #(
    parameter int                   N_IN     = 3,
    parameter int                   HOLD     = 2,
    parameter logic [(2**N_IN)-1:0] EXPECTED = 8'h1E
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  lu_s,
    output logic                  lu_a,
    output logic                  lu_b,
    output logic                  lu_sel,
    output logic                  busy,
    output logic                  done,
    output logic [(2**N_IN)-1:0]  result
`ifdef LU_CHECK_EN
    ,
    output logic                  mismatch
`endif
);

    localparam int                  c_NUM_COMBOS = 2**N_IN;
    localparam int                  c_HOLD_W     = $clog2(HOLD + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST  = c_HOLD_W'(HOLD - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE   = c_HOLD_W'(1);
    localparam logic [N_IN-1:0]     c_IDX_LAST   = N_IN'(c_NUM_COMBOS - 1);
    localparam logic [N_IN-1:0]     c_IDX_ONE    = N_IN'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [N_IN-1:0]         r_idx;
    logic [N_IN-1:0]         w_idx_inc;
    logic [c_HOLD_W-1:0]     r_hold_cnt;
    logic [N_IN-1:0]         r_drive;
    logic                    w_accept;
    logic                    w_sample;
    logic                    w_last;
    logic [c_NUM_COMBOS-1:0] w_result_upd;

    // The LU inputs come straight from a dedicated register, so they are glitch-free.
    assign lu_sel = r_drive[N_IN-1];
    assign lu_a   = r_drive[1];
    assign lu_b   = r_drive[0];

    // Next-state decode, sample strobe, and the result vector with the current sample merged in.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_sample     = 1'b0;
        w_last       = 1'b0;
        w_idx_inc    = r_idx + c_IDX_ONE;
        w_result_upd = result;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (r_hold_cnt == c_HOLD_LAST) begin
                    w_sample             = 1'b1;
                    w_result_upd[r_idx]  = lu_s;
                    if (r_idx == c_IDX_LAST) begin
                        w_last       = 1'b1;
                        w_state_next = c_ST_DONE;
                    end
                end
            end
            c_ST_DONE: begin
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sweep datapath: the index, the hold counter, the LU drive, and the result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_hold_cnt <= '0;
            r_drive    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
        end else begin
            busy <= (w_state_next != c_ST_IDLE);
            done <= (w_state_next == c_ST_DONE);
            if (w_accept) begin
                result     <= '0;
                r_idx      <= '0;
                r_hold_cnt <= '0;
                r_drive    <= '0;
            end else if (w_sample) begin
                result     <= w_result_upd;
                r_idx      <= w_idx_inc;
                r_hold_cnt <= '0;
                // After the last combo, the index wraps. The drive is parked at zero
                // instead of re-presenting combo 0.
                r_drive    <= w_last ? '0 : w_idx_inc;
            end else if (r_state == c_ST_RUN) begin
                r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
            end else begin
                r_drive    <= '0;
            end
        end
    end

`ifdef LU_CHECK_EN
    // The golden compare is taken on the final sample edge, so it includes the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch <= 1'b0;
        end else if (w_accept) begin
            mismatch <= 1'b0;
        end else if (w_last) begin
            mismatch <= (w_result_upd != EXPECTED);
        end
    end
`else
    logic w_unused_expected;
    assign w_unused_expected = ^EXPECTED;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lu_truth_table_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lu_truth_table_sequencer
// Description : Directed, table-driven bench for lu_truth_table_sequencer.
//               Instantiates a HOLD=2 DUT with a switchable LU model and a
//               HOLD=1 DUT with the real OR/NOR LU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lu_truth_table_sequencer;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [2:0] drive;
    } trace_t;

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] exp_result;
        logic       exp_mismatch;
    } cfg_t;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       start  = 1'b0;
    logic       start1 = 1'b0;
    logic [1:0] mode   = 2'd0;

    logic       lu_s, lu_a, lu_b, lu_sel, busy, done;
    logic [7:0] result;
    logic       lu_s1, lu_a1, lu_b1, lu_sel1, busy1, done1;
    logic [7:0] result1;
`ifdef LU_CHECK_EN
    logic       mismatch, mismatch1;
`endif

    int checks = 0;
    int errors = 0;

    trace_t trace [0:17];
    cfg_t   cfgs  [0:3];

    always #5 clk = ~clk;

    // LU model. Mode 0 is the real f7 (OR when sel=0, NOR when sel=1), mode 1 is stuck-at-0, and mode 2 is stuck-at-1.
    function automatic logic lu_model(input logic [1:0] m, input logic sel, input logic a, input logic b);
        case (m)
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            default: return sel ? ~(a | b) : (a | b);
        endcase
    endfunction

    assign lu_s  = lu_model(mode, lu_sel, lu_a, lu_b);
    assign lu_s1 = lu_model(2'd0, lu_sel1, lu_a1, lu_b1);

    lu_truth_table_sequencer #(.N_IN(3), .HOLD(2), .EXPECTED(8'h1E)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .lu_s(lu_s),
        .lu_a(lu_a), .lu_b(lu_b), .lu_sel(lu_sel),
        .busy(busy), .done(done), .result(result)
`ifdef LU_CHECK_EN
        , .mismatch(mismatch)
`endif
    );

    lu_truth_table_sequencer #(.N_IN(3), .HOLD(1), .EXPECTED(8'h1E)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .lu_s(lu_s1),
        .lu_a(lu_a1), .lu_b(lu_b1), .lu_sel(lu_sel1),
        .busy(busy1), .done(done1), .result(result1)
`ifdef LU_CHECK_EN
        , .mismatch(mismatch1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse start for one cycle. The task returns at the first negedge after the accept edge (k=0).
    task automatic pulse_start;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Count the cycles from k=0 until done is seen, bounded at 100.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Watchdog that guards against a hung run.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  lat;
        bit  seen_done, seen_busy;

        // Expected trace for a HOLD=2 sweep. Entry k is the value seen after edge t0+k.
        trace[0]  = '{1'b1, 1'b0, 3'd0};
        trace[1]  = '{1'b1, 1'b0, 3'd0};
        trace[2]  = '{1'b1, 1'b0, 3'd1};
        trace[3]  = '{1'b1, 1'b0, 3'd1};
        trace[4]  = '{1'b1, 1'b0, 3'd2};
        trace[5]  = '{1'b1, 1'b0, 3'd2};
        trace[6]  = '{1'b1, 1'b0, 3'd3};
        trace[7]  = '{1'b1, 1'b0, 3'd3};
        trace[8]  = '{1'b1, 1'b0, 3'd4};
        trace[9]  = '{1'b1, 1'b0, 3'd4};
        trace[10] = '{1'b1, 1'b0, 3'd5};
        trace[11] = '{1'b1, 1'b0, 3'd5};
        trace[12] = '{1'b1, 1'b0, 3'd6};
        trace[13] = '{1'b1, 1'b0, 3'd6};
        trace[14] = '{1'b1, 1'b0, 3'd7};
        trace[15] = '{1'b1, 1'b0, 3'd7};
        trace[16] = '{1'b1, 1'b1, 3'd0};
        trace[17] = '{1'b0, 1'b0, 3'd0};

        // Each entry gives an LU model and the result and mismatch it should produce.
        cfgs[0] = '{2'd0, 8'h1E, 1'b0};
        cfgs[1] = '{2'd1, 8'h00, 1'b1};
        cfgs[2] = '{2'd2, 8'hFF, 1'b1};
        cfgs[3] = '{2'd0, 8'h1E, 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   busy, 0);
        check("rst_done",   done, 0);
        check("rst_result", result, 8'h00);
        check("rst_drive",  {lu_sel, lu_a, lu_b}, 3'd0);
        check("rst_busy1",  busy1, 0);
`ifdef LU_CHECK_EN
        check("rst_mismatch", mismatch, 0);
`endif
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // Cycle-by-cycle trace of one sweep against the real LU.
        pulse_start;
        for (int k = 0; k < 18; k++) begin
            check($sformatf("trace_k%0d", k), {busy, done, lu_sel, lu_a, lu_b}, trace[k]);
            @(negedge clk);
        end
        check("trace_result", result, 8'h1E);

        // Sweeps with different LU models.
        for (int i = 0; i < 4; i++) begin
            mode = cfgs[i].mode;
            @(negedge clk);
            pulse_start;
            wait_done(lat);
            check($sformatf("cfg%0d_latency", i), lat, 16);
            check($sformatf("cfg%0d_result", i), result, cfgs[i].exp_result);
`ifdef LU_CHECK_EN
            check($sformatf("cfg%0d_mismatch_done", i), mismatch, cfgs[i].exp_mismatch);
`endif
            @(negedge clk);
            check($sformatf("cfg%0d_done_one_cycle", i), done, 0);
            check($sformatf("cfg%0d_idle_busy", i), busy, 0);
            repeat (3) @(negedge clk);
            check($sformatf("cfg%0d_result_held", i), result, cfgs[i].exp_result);
`ifdef LU_CHECK_EN
            check($sformatf("cfg%0d_mismatch_held", i), mismatch, cfgs[i].exp_mismatch);
`endif
        end
        mode = 2'd0;

        // Hold start high continuously. The two sweeps must not overlap, and there must be
        // exactly one IDLE cycle between them.
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 36; k++) begin
            check($sformatf("cont_busy_k%0d", k), busy, ((k % 18) != 17));
            check($sformatf("cont_done_k%0d", k), done, ((k % 18) == 16));
            if (k == 0 || k == 18) check($sformatf("cont_clear_k%0d", k), result, 8'h00);
            if (k == 17) check("cont_result", result, 8'h1E);
            if (k == 35) start = 1'b0;
            @(negedge clk);
        end
        check("cont_no_third", busy, 0);

        // Assert reset mid-sweep at idx=4. The outputs must clear without a clock edge.
        @(negedge clk);
        pulse_start;
        repeat (8) @(negedge clk);
        check("abort_drive_idx4", {lu_sel, lu_a, lu_b}, 3'd4);
        check("abort_partial_result", result, 8'h0E);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy",   busy, 0);
        check("abort_done",   done, 0);
        check("abort_drive",  {lu_sel, lu_a, lu_b}, 3'd0);
        check("abort_result", result, 8'h00);
`ifdef LU_CHECK_EN
        check("abort_mismatch", mismatch, 0);
`endif
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        seen_done = 1'b0;
        seen_busy = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            if (busy) seen_busy = 1'b1;
        end
        check("abort_no_done", seen_done, 0);
        check("abort_stays_idle", seen_busy, 0);

        // HOLD=1 instance. A start pulse during RUN must have no effect.
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        lat = 0;
        while (done1 !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            start1 = (lat == 3);
        end
        start1 = 1'b0;
        check("h1_latency", lat, 8);
        check("h1_result", result1, 8'h1E);
        @(negedge clk);
        check("h1_done_one_cycle", done1, 0);
        check("h1_idle_busy", busy1, 0);
        seen_busy = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy1) seen_busy = 1'b1;
        end
        check("h1_no_restart", seen_busy, 0);
        check("h1_result_held", result1, 8'h1E);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
